irom_arbiter: RTL and testbench
===============================

# irom_arbiter

Two-port sequencing controller placed in front of the byte-wide instruction ROM (`irom`). It shares the ROM's single AHB-style port between an instruction-fetch requester and a loader/debug requester. It turns each fetch into four pipelined byte reads that assemble one 32-bit little-endian instruction, and turns each loader access into one byte read or write. It drives the ROM's HADDR/HTRANS/HWRITE/HWDATA and samples HRDATA[7:0]; the ROM has one-cycle registered read latency and decodes no HTRANS.

## Interface
Parameters:
- ROM_START, 64'h0, base byte address of the ROM window.
- ROM_SIZE, 256, ROM size in bytes.

Ports:
- HCLK  in  1  single clock.
- HRESET  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held until f_done.
- f_addr  in  64  fetch byte address; stable while f_req is high.
- f_done  out  1  one-cycle completion pulse.
- f_rdata  out  32  {b3,b2,b1,b0}; valid only while f_done is high.
- f_err  out  1  asserted with f_done when the fetch was rejected.
- l_req  in  1  loader request; held until l_done.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  64  loader byte address.
- l_wdata  in  8  write byte.
- l_done  out  1  one-cycle completion pulse.
- l_rdata  out  8  read byte; valid only while l_done is high.
- l_err  out  1  asserted with l_done when the access was rejected.
- HADDR  out  64  ROM address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HWRITE  out  1  ROM write strobe.
- HWDATA  out  64  {56'b0, byte}.
- HRDATA  in  64  ROM read data; only [7:0] is used.

## Operation
- States:
  - IDLE: requests are sampled only here.
  - F_ISSUE: 4 beats, driven by a 2-bit beat counter.
  - F_DRAIN: 1 cycle.
  - L_ISSUE: 1 cycle.
  - L_WAIT: 1 cycle, reads only.
  - RESP: 1 cycle.
- Arbitration in IDLE:
  - Two-way round-robin. The priority pointer resets to fetch and flips to the other port after every grant.
  - A lone requester is always granted.
- Range check at grant:
  - A fetch is legal iff ROM_START ≤ f_addr and f_addr+3 < ROM_START+ROM_SIZE. The comparison is 65-bit so it cannot wrap.
  - A loader access is legal iff l_addr lies in the window.
  - An illegal request makes no bus access and goes straight to RESP with the error flag set and rdata = 0.
- Fetch sequence:
  - F_ISSUE beat k drives HADDR = f_addr+k; HTRANS is NONSEQ for k=0 and SEQ for k=1..3.
  - The byte for beat k is captured from HRDATA[7:0] one cycle after beat k is issued: beats 1..3 of F_ISSUE capture bytes 0..2, and F_DRAIN captures byte 3.
- Loader read: L_ISSUE drives HADDR, NONSEQ, HWRITE=0; L_WAIT captures HRDATA[7:0].
- Loader write: L_ISSUE drives HADDR, NONSEQ, HWRITE=1, HWDATA[7:0] = l_wdata. The ROM commits the byte at the end of that cycle, and the FSM then goes directly to RESP.
- Bus behaviour outside an active beat:
  - The ROM ignores HTRANS, so HWRITE must be 1 only in a loader-write L_ISSUE cycle.
  - Outside active beats: HTRANS=00, HADDR=0, HWDATA=0, HWRITE=0.
- RESP pulses the granted port's done signal, then returns to IDLE.
- Request line rules:
  - A requester that drops req mid-transaction does not abort it; done still pulses.
  - req still high in the IDLE cycle after done is treated as a new request.
- Reset: every output resets to 0 and the state resets to IDLE. A reset asserted mid-transaction aborts it with no done pulse; a write already issued may have committed.

## Timing
- Times are counted from cycle T, in which a request is sampled in IDLE.
- Fetch:
  - Beats are issued in T+1..T+4; HRDATA bytes are valid in T+2..T+5.
  - f_done, f_rdata and f_err are asserted in T+6.
  - The next grant is possible at T+7.
- Loader read: issue in T+1, capture in T+2, l_done in T+3.
- Loader write: issue in T+1, l_done in T+2.
- Rejected request (either port): done pulses at T+1.
- done, rdata and err are registered outputs; none combinationally depends on req.

## Configuration
- IROM_ARB_LOADER_WRITE_EN defined: loader writes are performed as described above.
- Undefined: any loader request with l_we=1 is rejected. It gets l_err=1 and l_done at T+1, with no bus access, and HWRITE is tied to 0. Loader reads are unaffected.

## Structure
- Shared package irom_pkg holds:
  - the state encodings;
  - the HTRANS constants IDLE/NONSEQ/SEQ;
  - the port-ID constants (FETCH=0, LOADER=1).
- Sub-module irom_rr_arb: two-way round-robin arbiter with inputs req[1:0] and an advance strobe, outputs a one-hot grant, and holds the pointer register.

## Test plan
- ROM reset-initialised (byte i = i). Fetch from 0x10 → HADDR 0x10..0x13 in T+1..T+4, then f_done at T+6 with f_rdata=32'h13121110 and f_err=0.
- Loader write 0xAB to 0x05 (macro defined), then fetch from 0x04 → l_done at T+2, then f_rdata=32'h0706AB04.
- f_req and l_req both high out of reset → fetch is granted first, the loader next, then fetch again if both stay asserted (alternation).
- Fetch at ROM_START+ROM_SIZE-2, and loader access at 0x100 → f_err=1 and l_err=1 with rdata=0 at T+1, and HTRANS stays 00 throughout.
- Macro undefined, loader write → l_err=1 at T+1, HWRITE never 1, and a later fetch of the target address returns the original data.
- HRESET asserted during fetch beat 2 → all outputs are 0 the next cycle, no f_done, the FSM is in IDLE, and a new fetch completes normally.

Source files
------------

// File: rtl/irom_pkg.sv
// irom_pkg: constants shared by the irom_arbiter slice.
//   - FSM state encodings
//   - HTRANS encodings (IDLE / NONSEQ / SEQ)
//   - requester port IDs (fetch = 0, loader = 1)
package irom_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_F_ISSUE = 3'd1;
  localparam logic [2:0] S_F_DRAIN = 3'd2;
  localparam logic [2:0] S_L_ISSUE = 3'd3;
  localparam logic [2:0] S_L_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic PORT_FETCH  = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/irom_rr_arb.sv
// irom_rr_arb: two-way round-robin arbiter.
// Ports:
//   HCLK, HRESET  clock, synchronous active-high reset
//   req[1:0]      request vector (bit 0 = fetch, bit 1 = loader)
//   advance       grant is being taken this cycle; pointer moves past the winner
//   grant[1:0]    one-hot grant (zero when nothing requests)
module irom_rr_arb
  import irom_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr names the port that wins a tie
  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = (ptr == PORT_LOADER) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ptr <= PORT_FETCH;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0] ? PORT_LOADER : PORT_FETCH;
    end
  end

endmodule

// File: rtl/irom_arbiter.sv
// irom_arbiter: shares the byte-wide irom port between an instruction-fetch
// requester (4 pipelined byte reads -> one 32-bit little-endian word) and a
// loader/debug requester (single byte read or write).
// Ports:
//   HCLK, HRESET                    clock, synchronous active-high reset
//   f_req/f_addr                    fetch request and byte address
//   f_done/f_rdata/f_err            fetch completion pulse, word, reject flag
//   l_req/l_we/l_addr/l_wdata       loader request
//   l_done/l_rdata/l_err            loader completion pulse, byte, reject flag
//   HADDR/HTRANS/HWRITE/HWDATA      ROM bus outputs
//   HRDATA                          ROM read data (only [7:0] used)
// Build option: IROM_ARB_LOADER_WRITE_EN enables loader writes; without it
// every loader write is rejected and HWRITE stays 0.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | sample requests, arbitrate, range-check
// S_F_ISSUE | four fetch beats (beat counter), capture bytes 0..2
// S_F_DRAIN | capture byte 3
// S_L_ISSUE | loader beat (read or write)
// S_L_WAIT  | capture loader read byte
// S_RESP    | done/rdata/err visible, back to idle
module irom_arbiter
  import irom_pkg::*;
#(
  parameter logic [63:0] ROM_START = 64'h0,
  parameter int unsigned ROM_SIZE  = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [63:0] l_addr,
  input  logic [7:0]  l_wdata,
  output logic        l_done,
  output logic [7:0]  l_rdata,
  output logic        l_err,
  output logic [63:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA
);

`ifdef IROM_ARB_LOADER_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  // 65-bit window bounds so f_addr+3 cannot wrap past 2^64
  localparam logic [64:0] WIN_LO = {1'b0, ROM_START};
  localparam logic [64:0] WIN_HI = {1'b0, ROM_START} + 65'(ROM_SIZE);

  logic [2:0]  state;
  logic [1:0]  beat;
  logic [63:0] addr_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic [23:0] asm_q;
  logic [1:0]  grant;
  logic        f_legal, l_ok;
  logic        hrdata_unused;

  assign hrdata_unused = ^HRDATA[63:8];

  assign f_legal = ({1'b0, f_addr} >= WIN_LO) && (({1'b0, f_addr} + 65'd3) < WIN_HI);
  assign l_ok    = ({1'b0, l_addr} >= WIN_LO) && ({1'b0, l_addr} < WIN_HI) && (WR_EN || !l_we);

  irom_rr_arb u_arb (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .req     ({l_req, f_req}),
    .advance (state == S_IDLE),
    .grant   (grant)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      beat    <= 2'd0;
      addr_q  <= 64'd0;
      we_q    <= 1'b0;
      wdata_q <= 8'd0;
      asm_q   <= 24'd0;
      f_done  <= 1'b0;
      f_rdata <= 32'd0;
      f_err   <= 1'b0;
      l_done  <= 1'b0;
      l_rdata <= 8'd0;
      l_err   <= 1'b0;
    end else begin
      // response registers are one-cycle pulses, zero outside RESP
      f_done  <= 1'b0;
      f_rdata <= 32'd0;
      f_err   <= 1'b0;
      l_done  <= 1'b0;
      l_rdata <= 8'd0;
      l_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          beat <= 2'd0;
          if (grant[0]) begin
            addr_q <= f_addr;
            if (f_legal) begin
              state <= S_F_ISSUE;
            end else begin
              state  <= S_RESP;
              f_done <= 1'b1;
              f_err  <= 1'b1;
            end
          end else if (grant[1]) begin
            addr_q  <= l_addr;
            we_q    <= l_we;
            wdata_q <= l_wdata;
            if (l_ok) begin
              state <= S_L_ISSUE;
            end else begin
              state  <= S_RESP;
              l_done <= 1'b1;
              l_err  <= 1'b1;
            end
          end
        end
        S_F_ISSUE: begin
          // HRDATA lags HADDR by one cycle: beat k collects byte k-1
          if (beat != 2'd0) asm_q <= {HRDATA[7:0], asm_q[23:8]};
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= S_F_DRAIN;
        end
        S_F_DRAIN: begin
          state   <= S_RESP;
          f_done  <= 1'b1;
          f_rdata <= {HRDATA[7:0], asm_q};
        end
        S_L_ISSUE: begin
          if (WR_EN && we_q) begin
            state  <= S_RESP;
            l_done <= 1'b1;
          end else begin
            state <= S_L_WAIT;
          end
        end
        S_L_WAIT: begin
          state   <= S_RESP;
          l_done  <= 1'b1;
          l_rdata <= HRDATA[7:0];
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // bus is quiet (all zero) except in issue beats
  always_comb begin
    HADDR  = 64'd0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HWDATA = 64'd0;
    case (state)
      S_F_ISSUE: begin
        HADDR  = addr_q + {62'd0, beat};
        HTRANS = (beat == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      end
      S_L_ISSUE: begin
        HADDR  = addr_q;
        HTRANS = HTRANS_NONSEQ;
        if (WR_EN && we_q) begin
          HWRITE = 1'b1;
          HWDATA = {56'd0, wdata_q};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irom_arbiter.sv
module tb_irom_arbiter;

  localparam logic [63:0] ROM_START = 64'h0;
  localparam int ROM_SIZE = 256;
`ifdef IROM_ARB_LOADER_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        f_req = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [63:0] f_addr = '0, l_addr = '0;
  logic [7:0]  l_wdata = '0;
  logic        f_done, f_err, l_done, l_err, HWRITE;
  logic [31:0] f_rdata;
  logic [7:0]  l_rdata;
  logic [63:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;

  always #5 HCLK = ~HCLK;

  irom_arbiter #(.ROM_START(ROM_START), .ROM_SIZE(ROM_SIZE)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_done(l_done), .l_rdata(l_rdata), .l_err(l_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  // ROM fixture: byte i = i at start, one-cycle registered read, write on HWRITE
  logic [7:0] rom [0:255];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    HRDATA = '0;
    forever begin
      @(posedge HCLK);
      HRDATA <= {56'd0, rom[HADDR[7:0]]};
      if (HWRITE) rom[HADDR[7:0]] <= HWDATA[7:0];
    end
  end

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // reference model state
  typedef struct { logic port; logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t sb[$];
  logic [130:0] exp_bus [int];
  logic [7:0] mem_m [0:255];
  bit rr_ptr = 1'b0;
  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b1, bus_chk_en = 1'b0;

  // monitor: pops the scoreboard on every done pulse; checks bus trace every cycle
  exp_t e;
  logic [31:0] act_data;
  logic [130:0] exp_b, act_b;
  always @(negedge HCLK) begin
    if (mon_en && (f_done || l_done)) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d f_done=%0b l_done=%0b", cyc, f_done, l_done);
      end else begin
        e = sb.pop_front();
        act_data = l_done ? {24'd0, l_rdata} : f_rdata;
        if ((f_done && l_done) || (l_done != e.port) || (act_data != e.rdata) ||
            ((l_done ? l_err : f_err) != e.err) || (cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL response cyc=%0d port=%0b data=%h err=%0b required cyc=%0d port=%0b data=%h err=%0b",
                   cyc, l_done, act_data, l_done ? l_err : f_err, e.cyc, e.port, e.rdata, e.err);
        end
      end
    end
    if (bus_chk_en) begin
      n_chk++;
      exp_b = exp_bus.exists(cyc) ? exp_bus[cyc] : '0;
      act_b = {HTRANS, HADDR, HWRITE, HWDATA};
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL bus cyc=%0d htrans=%b haddr=%h hwrite=%b hwdata=%h required htrans=%b haddr=%h hwrite=%b hwdata=%h",
                 cyc, HTRANS, HADDR, HWRITE, HWDATA, exp_b[130:129], exp_b[128:65], exp_b[64], exp_b[63:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // predict one granted access sampled at edge eg; returns its length in cycles
  task automatic model_item(input logic port, input logic [63:0] a, input logic we,
                            input logic [7:0] wd, input int eg, output int lat);
    exp_t x;
    int idx;
    x.port = port; x.rdata = '0; x.err = 1'b0;
    idx = int'(a[7:0] - ROM_START[7:0]);
    if (port == 1'b0) begin
      if (a >= ROM_START && (a - ROM_START) <= 64'(ROM_SIZE - 4)) begin
        for (int k = 0; k < 4; k++) begin
          x.rdata[8*k +: 8] = mem_m[idx + k];
          exp_bus[eg + k] = {(k == 0) ? 2'b10 : 2'b11, a + 64'(k), 1'b0, 64'd0};
        end
        lat = 6;
      end else begin
        x.err = 1'b1; lat = 1;
      end
    end else begin
      if (a >= ROM_START && (a - ROM_START) < 64'(ROM_SIZE) && (WR_EN || !we)) begin
        exp_bus[eg] = {2'b10, a, we, we ? {56'd0, wd} : 64'd0};
        if (we) begin mem_m[idx] = wd; lat = 2; end
        else begin x.rdata = {24'd0, mem_m[idx]}; lat = 3; end
      end else begin
        x.err = 1'b1; lat = 1;
      end
    end
    x.cyc = eg + lat - 1;
    sb.push_back(x);
  endtask

  // mode bit0 = fetch, bit1 = loader; called on a negedge with the DUT idle
  task automatic do_round(input int mode, input logic [63:0] fa, input logic [63:0] la,
                          input logic lwe, input logic [7:0] lwd);
    int eg, lat, budget;
    eg = cyc + 1;
    if (mode == 3) begin
      if (rr_ptr == 1'b0) begin
        model_item(1'b0, fa, 1'b0, 8'd0, eg, lat); eg += lat + 1;
        model_item(1'b1, la, lwe, lwd, eg, lat);
      end else begin
        model_item(1'b1, la, lwe, lwd, eg, lat); eg += lat + 1;
        model_item(1'b0, fa, 1'b0, 8'd0, eg, lat);
      end
    end else if (mode == 1) begin
      model_item(1'b0, fa, 1'b0, 8'd0, eg, lat); rr_ptr = 1'b1;
    end else begin
      model_item(1'b1, la, lwe, lwd, eg, lat); rr_ptr = 1'b0;
    end
    f_addr = fa; l_addr = la; l_we = lwe; l_wdata = lwd;
    f_req = (mode & 1) != 0;
    l_req = (mode & 2) != 0;
    budget = 0;
    while ((f_req || l_req) && budget < 60) begin
      @(negedge HCLK);
      budget++;
      if (f_done) f_req = 1'b0;
      if (l_done) l_req = 1'b0;
    end
    n_chk++;
    if (f_req || l_req) begin
      n_fail++;
      $display("FAIL done_timeout pending f=%0b l=%0b required none", f_req, l_req);
      f_req = 1'b0; l_req = 1'b0;
    end
    repeat (1 + $urandom_range(0, 2)) @(negedge HCLK);
  endtask

  initial begin
    int m;
    logic [63:0] fa, la;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
    repeat (3) @(negedge HCLK);
    chk("reset_f_done", 64'(f_done), 0);
    chk("reset_f_rdata", 64'(f_rdata), 0);
    chk("reset_l_done", 64'(l_done), 0);
    chk("reset_htrans", 64'(HTRANS), 0);
    chk("reset_haddr", HADDR, 0);
    HRESET = 1'b0;
    bus_chk_en = 1'b1;

    do_round(3, 64'h10, 64'h30, 1'b0, 8'h00);      // tie out of reset: fetch first
    do_round(1, 64'h10, 64'h00, 1'b0, 8'h00);      // 32'h13121110
    do_round(3, 64'h20, 64'h31, 1'b0, 8'h00);      // pointer now at loader
    do_round(2, 64'h00, 64'h05, 1'b1, 8'hAB);      // loader write
    do_round(1, 64'h04, 64'h00, 1'b0, 8'h00);      // reads back written byte
    do_round(3, 64'(ROM_SIZE - 2), 64'h100, 1'b0, 8'h00);
    do_round(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0, 8'h00);
    do_round(1, 64'(ROM_SIZE - 4), 64'h0, 1'b0, 8'h00);
    do_round(2, 64'h0, 64'(ROM_SIZE - 1), 1'b0, 8'h00);

    for (int r = 0; r < 200; r++) begin
      m = $urandom_range(1, 3);
      case ($urandom_range(0, 9))
        8: fa = 64'($urandom_range(253, 300));
        9: fa = {$urandom, $urandom};
        default: fa = 64'($urandom_range(0, 252));
      endcase
      case ($urandom_range(0, 9))
        8: la = 64'($urandom_range(256, 300));
        9: la = {$urandom, $urandom};
        default: la = 64'($urandom_range(0, 255));
      endcase
      do_round(m, fa, la, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // reset during fetch beat 2: aborted with no done pulse
    bus_chk_en = 1'b0;
    f_addr = 64'h40; f_req = 1'b1;
    m = cyc + 1;
    for (int k = 0; k < 20 && cyc < m + 2; k++) @(negedge HCLK);
    chk("beat2_haddr", HADDR, 64'h42);
    HRESET = 1'b1; f_req = 1'b0;
    @(negedge HCLK);
    chk("rst_f_done", 64'(f_done), 0);
    chk("rst_f_rdata", 64'(f_rdata), 0);
    chk("rst_f_err", 64'(f_err), 0);
    chk("rst_l_done", 64'(l_done), 0);
    chk("rst_htrans", 64'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", 64'(HWRITE), 0);
    chk("rst_hwdata", HWDATA, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    rr_ptr = 1'b0;
    exp_bus.delete();
    bus_chk_en = 1'b1;
    do_round(3, 64'h40, 64'h41, 1'b0, 8'h00);
    do_round(1, 64'h44, 64'h00, 1'b0, 8'h00);

    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
